// File: rtl/gen_bus_rr_arbiter.sv
// Round-robin arbiter sharing one generic bus between NUM_REQ requesters, one transaction in flight.
// Optional bus watchdog enabled by defining ARB_WATCHDOG_EN.
module gen_bus_rr_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BE_W          = DATA_W / 8
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [NUM_REQ-1:0]        req_ren,
    input  logic [NUM_REQ-1:0]        req_wen,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*BE_W-1:0]   req_byte_en,
    output logic [NUM_REQ*DATA_W-1:0] req_rdata,
    output logic [NUM_REQ-1:0]        req_busy,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [DATA_W-1:0]         out_wdata,
    output logic                      out_ren,
    output logic                      out_wen,
    output logic [BE_W-1:0]           out_byte_en,
    input  logic [DATA_W-1:0]         out_rdata,
    input  logic                      out_busy,
    input  logic                      abort_bus,
    output logic                      grant_valid,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      timeout,
    output logic [1:0]                dbg_state_o
);

    // Handshake: a requester holds ren/wen/addr/wdata/byte_en stable until its req_busy is low;
    // that low cycle is the completion cycle and req_rdata is valid in it.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win;
    logic               grant_valid_q, grant_valid_d;
    logic [NUM_REQ-1:0] active;
    logic               g_ren, g_wen, found, wd_fire;

    assign active = req_ren | req_wen;
    assign g_ren  = req_ren[grant_idx_q];
    assign g_wen  = req_wen[grant_idx_q];

`ifdef ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

    assign wd_fire = (state_q != IDLE) && out_busy && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cleared on firing so the RECOVER phase gets its own full timeout window.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == IDLE) begin
            wd_cnt_d = '0;
        end else if (out_busy) begin
            wd_cnt_d = wd_fire ? '0 : wd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign timeout = wd_fire & nRST;
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        int idx;
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        ptr_d         = ptr_q;
        found         = 1'b0;
        win           = ptr_q;
        idx           = 0;
        out_addr      = '0;
        out_wdata     = '0;
        out_byte_en   = '0;
        out_ren       = 1'b0;
        out_wen       = 1'b0;
        req_busy      = '1;

        case (state_q)
            IDLE: begin
                if (!abort_bus) begin
                    // Search downwards from the pointer, wrapping modulo NUM_REQ.
                    for (int k = 0; k < NUM_REQ; k++) begin
                        idx = int'(ptr_q) - k;
                        if (idx < 0) idx = idx + NUM_REQ;
                        if (!found && active[idx]) begin
                            found = 1'b1;
                            win   = IDX_W'(idx);
                        end
                    end
                end
                if (found) begin
                    grant_idx_d   = win;
                    grant_valid_d = 1'b1;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                out_addr              = req_addr[grant_idx_q*ADDR_W +: ADDR_W];
                out_wdata             = req_wdata[grant_idx_q*DATA_W +: DATA_W];
                out_byte_en           = req_byte_en[grant_idx_q*BE_W +: BE_W];
                out_ren               = g_ren;
                out_wen               = g_wen;
                req_busy[grant_idx_q] = out_busy;
                if (!out_busy) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    ptr_d         = (grant_idx_q == '0) ? IDX_W'(NUM_REQ - 1) : grant_idx_q - IDX_W'(1);
                end else if (abort_bus || !(g_ren | g_wen) || wd_fire) begin
                    out_ren       = 1'b0;
                    out_wen       = 1'b0;
                    state_d       = RECOVER;
                    grant_valid_d = 1'b0;
                end
            end
            RECOVER: begin
                if (!out_busy || wd_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The slave sees the request vanish as soon as reset is asserted.
        if (!nRST) begin
            out_addr    = '0;
            out_wdata   = '0;
            out_byte_en = '0;
            out_ren     = 1'b0;
            out_wen     = 1'b0;
            req_busy    = '1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q       <= IDLE;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            ptr_q         <= ptr_d;
        end
    end

    assign req_rdata   = {NUM_REQ{out_rdata}};
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gen_bus_rr_arbiter.sv
// Bench for gen_bus_rr_arbiter: vector table for arbitration/abort/withdraw, hand sequence for the watchdog.
module tb_gen_bus_rr_arbiter;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int EW = 41;
    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_A = 2'd1;
    localparam logic [1:0] S_R = 2'd2;

    logic           CLK, nRST;
    logic [NR-1:0]  req_ren, req_wen, req_busy;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata, req_rdata;
    logic [NR*BW-1:0] req_byte_en;
    logic [AW-1:0]  out_addr;
    logic [DW-1:0]  out_wdata, out_rdata;
    logic           out_ren, out_wen, out_busy, abort_bus, grant_valid, timeout;
    logic [BW-1:0]  out_byte_en;
    logic [0:0]     grant_idx;
    logic [1:0]     dbg_state;

    gen_bus_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_byte_en(req_byte_en), .req_rdata(req_rdata), .req_busy(req_busy),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_ren(out_ren), .out_wen(out_wen),
        .out_byte_en(out_byte_en), .out_rdata(out_rdata), .out_busy(out_busy), .abort_bus(abort_bus),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout(timeout), .dbg_state_o(dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  ren;
        logic [1:0]  wen;
        logic        obusy;
        logic        abort;
        logic        eoren;
        logic        eowen;
        logic [1:0]  ebusy;
        logic        egv;
        logic        egi;
        logic [1:0]  est;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[31];
    logic [EW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    function automatic vec_t mk(input logic [1:0] ren, input logic [1:0] wen, input logic ob,
                                input logic ab, input logic oren, input logic owen,
                                input logic [1:0] busy, input logic gv, input logic gi,
                                input logic [1:0] st, input logic [31:0] addr);
        vec_t v;
        v.ren = ren; v.wen = wen; v.obusy = ob; v.abort = ab; v.eoren = oren; v.eowen = owen;
        v.ebusy = busy; v.egv = gv; v.egi = gi; v.est = st; v.eaddr = addr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [EW-1:0] e;
        vec_t          v;
        logic [DW-1:0] ew;
        logic [BW-1:0] eb;
        logic [1:0]    est;
        logic          eto, eoren;
        int            n;

        // ren, wen, out_busy, abort | out_ren, out_wen, req_busy, grant_valid, grant_idx, state, out_addr
        vecs[0]  = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, S_I, 32'h0);
        vecs[1]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, S_I, 32'h0);
        vecs[2]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, S_A, 32'h100);
        vecs[3]  = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, S_I, 32'h0);
        vecs[4]  = mk(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, S_I, 32'h0);
        vecs[5]  = mk(2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, S_A, 32'h200);
        vecs[6]  = mk(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, S_A, 32'h200);
        vecs[7]  = mk(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, S_I, 32'h0);
        vecs[8]  = mk(2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, S_A, 32'h100);
        vecs[9]  = mk(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, S_A, 32'h100);
        vecs[10] = mk(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, S_I, 32'h0);
        vecs[11] = mk(2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, S_A, 32'h200);
        vecs[12] = mk(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, S_A, 32'h200);
        vecs[13] = mk(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, S_I, 32'h0);
        vecs[14] = mk(2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, S_A, 32'h100);
        vecs[15] = mk(2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, S_A, 32'h100);
        vecs[16] = mk(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, S_R, 32'h0);
        vecs[17] = mk(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, S_R, 32'h0);
        vecs[18] = mk(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, S_I, 32'h0);
        vecs[19] = mk(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, S_A, 32'h100);
        vecs[20] = mk(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, S_I, 32'h0);
        vecs[21] = mk(2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, S_A, 32'h200);
        vecs[22] = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, S_A, 32'h200);
        vecs[23] = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, S_R, 32'h0);
        vecs[24] = mk(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, S_I, 32'h0);
        vecs[25] = mk(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, S_A, 32'h100);
        vecs[26] = mk(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, S_I, 32'h0);
        vecs[27] = mk(2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, S_A, 32'h200);
        vecs[28] = mk(2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, S_I, 32'h0);
        vecs[29] = mk(2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, S_I, 32'h0);
        vecs[30] = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, S_I, 32'h0);

        nRST        = 1'b0;
        req_ren     = 2'b11;
        req_wen     = 2'b00;
        req_addr    = {32'h0000_0200, 32'h0000_0100};
        req_wdata   = {32'hB1B2_B3B4, 32'hA1A2_A3A4};
        req_byte_en = {4'hF, 4'($urandom_range(1, 14))};
        out_rdata   = $urandom();
        out_busy    = 1'b1;
        abort_bus   = 1'b0;

        for (int r = 0; r < 3; r++) begin
            @(posedge CLK); #1;
            out_rdata = $urandom();
            @(negedge CLK);
            chk($sformatf("rst%0d_out_ren", r), 64'(out_ren), 64'd0);
            chk($sformatf("rst%0d_out_addr", r), 64'(out_addr), 64'd0);
            chk($sformatf("rst%0d_req_busy", r), 64'(req_busy), 64'd3);
            chk($sformatf("rst%0d_grant_valid", r), 64'(grant_valid), 64'd0);
            chk($sformatf("rst%0d_timeout", r), 64'(timeout), 64'd0);
        end

        for (int i = 0; i < 31; i++) begin
            v = vecs[i];
            @(posedge CLK); #1;
            nRST      = 1'b1;
            req_ren   = v.ren;
            req_wen   = v.wen;
            out_busy  = v.obusy;
            abort_bus = v.abort;
            out_rdata = $urandom();
            exp_q.push_back({v.eoren, v.eowen, v.ebusy, v.egv, v.egi, v.est, 1'b0, v.eaddr});
            @(negedge CLK);
            e  = exp_q.pop_front();
            ew = (e[34:33] == S_A) ? req_wdata[e[35]*DW +: DW] : '0;
            eb = (e[34:33] == S_A) ? req_byte_en[e[35]*BW +: BW] : '0;
            chk($sformatf("v%0d_out_ren", i), 64'(out_ren), 64'(e[40]));
            chk($sformatf("v%0d_out_wen", i), 64'(out_wen), 64'(e[39]));
            chk($sformatf("v%0d_req_busy", i), 64'(req_busy), 64'(e[38:37]));
            chk($sformatf("v%0d_grant_valid", i), 64'(grant_valid), 64'(e[36]));
            chk($sformatf("v%0d_grant_idx", i), 64'(grant_idx), 64'(e[35]));
            chk($sformatf("v%0d_state", i), 64'(dbg_state), 64'(e[34:33]));
            chk($sformatf("v%0d_timeout", i), 64'(timeout), 64'(e[32]));
            chk($sformatf("v%0d_out_addr", i), 64'(out_addr), 64'(e[31:0]));
            chk($sformatf("v%0d_out_wdata", i), 64'(out_wdata), 64'(ew));
            chk($sformatf("v%0d_out_byte_en", i), 64'(out_byte_en), 64'(eb));
            chk($sformatf("v%0d_req_rdata", i), req_rdata, {out_rdata, out_rdata});
        end

        // Slave stuck busy on a read from requester 0.
        for (int k = 0; k < 18; k++) begin
            @(posedge CLK); #1;
            req_ren   = 2'b01;
            req_wen   = 2'b00;
            out_busy  = 1'b1;
            abort_bus = 1'b0;
`ifdef ARB_WATCHDOG_EN
            est   = (k == 0) ? S_I : (k <= 8) ? S_A : (k <= 16) ? S_R : S_I;
            eto   = (k == 8) || (k == 16);
            eoren = (k >= 1) && (k <= 7);
`else
            est   = (k == 0) ? S_I : S_A;
            eto   = 1'b0;
            eoren = (k >= 1);
`endif
            exp_q.push_back(EW'({eoren, eto, est}));
            @(negedge CLK);
            e = exp_q.pop_front();
            chk($sformatf("wd%0d_state", k), 64'(dbg_state), 64'(e[1:0]));
            chk($sformatf("wd%0d_timeout", k), 64'(timeout), 64'(e[2]));
            chk($sformatf("wd%0d_out_ren", k), 64'(out_ren), 64'(e[3]));
        end

        @(posedge CLK); #1;
        req_ren  = 2'b00;
        out_busy = 1'b0;
        n = 0;
        while (n < 10 && !(dbg_state === S_I && grant_valid === 1'b0)) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_idle_within_budget", 64'(n < 10), 64'd1);
        chk("drain_req_busy", 64'(req_busy), 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gen_bus_rr_arbiter.md
Name: gen_bus_rr_arbiter

Overview:
- Shares one downstream generic bus between NUM_REQ upstream generic bus requesters, for example I-fetch and D-access.
- Drop-in replacement for the bus_ctrl-based arbitration inside the memory controller.
- Round-robin grant with a registered grant; one outstanding transaction at a time.
- Supports abort on interrupt/flush, and request withdrawal by the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters; index NUM_REQ-1 = highest initial priority (data).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte_en width = DATA_W/8.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with ARB_WATCHDOG_EN).

Ports:
- CLK  in  1  clock, all logic posedge.
- nRST  in  1  reset; synchronous and active-low.
- req_ren  in  NUM_REQ  per-requester read enable.
- req_wen  in  NUM_REQ  per-requester write enable.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_byte_en  in  NUM_REQ*DATA_W/8  packed byte enables.
- req_rdata  out  NUM_REQ*DATA_W  read data, out_rdata broadcast to all slices.
- req_busy  out  NUM_REQ  per-requester busy; low exactly on that requester's completion cycle.
- out_addr  out  ADDR_W  downstream address.
- out_wdata  out  DATA_W  downstream write data.
- out_ren  out  1  downstream read enable.
- out_wen  out  1  downstream write enable.
- out_byte_en  out  DATA_W/8  downstream byte enables.
- out_rdata  in  DATA_W  downstream read data.
- out_busy  in  1  downstream busy; low = transaction complete this cycle.
- abort_bus  in  1  abort current transaction (interrupt/flush).
- grant_valid  out  1  a requester currently owns the bus.
- grant_idx  out  $clog2(NUM_REQ)  owning requester index.
- timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- States: IDLE, ACCESS, RECOVER.
- Reset (nRST low at posedge):
  - state=IDLE, grant_valid=0, grant_idx=0.
  - Priority pointer = NUM_REQ-1.
  - Watchdog count=0, timeout=0.
- Outputs while reset is held:
  - out_ren=0, out_wen=0, out_addr=0, out_wdata=0, out_byte_en=0.
  - req_busy all 1.
- Reset mid-transaction drops the request immediately; the downstream slave must tolerate a dropped ren/wen.
- Active requester: req_ren[i] | req_wen[i].
- Round-robin search: starts at the priority pointer and descends modulo NUM_REQ.
- IDLE:
  - Out enables = 0; all req_busy = 1.
  - If any requester is active: latch winner into grant_idx, grant_valid<=1, go to ACCESS.
  - Else stay in IDLE.
- ACCESS:
  - out_* combinationally mirror slice grant_idx.
  - Non-granted req_busy = 1; req_busy[grant_idx] = out_busy.
  - out_busy=0: completion. req_busy[grant_idx]=0 this cycle and req_rdata is valid. Next state IDLE, grant_valid<=0, pointer <= grant_idx-1 mod NUM_REQ (the winner gets lowest priority next).
  - abort_bus=1, or granted requester withdraws (ren|wen low), while out_busy=1:
    - Out enables forced to 0 this cycle; req_busy[grant_idx] stays 1.
    - Go to RECOVER; pointer unchanged.
- RECOVER:
  - Out enables = 0; all req_busy = 1.
  - Wait for out_busy=0, then go to IDLE. This drains the in-flight slave beat.
- Simultaneous events:
  - Completion (out_busy=0) and abort in the same cycle: completion wins and is reported normally.
  - abort_bus held in IDLE: no grant issued.
- Latency: request seen in cycle N → out_ren/out_wen asserted in cycle N+1. Minimum round trip is 2 cycles for a zero-wait slave.
- A requester must hold addr/wdata/byte_en/ren/wen stable until it sees req_busy low.
- ren and wen both set on one requester: forwarded unchanged; the arbiter does not check this.

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- With the macro:
  - A counter clears on entry to ACCESS and increments each cycle in ACCESS or RECOVER while out_busy=1.
  - On reaching TIMEOUT_CYCLES-1: timeout pulses 1 for one cycle.
  - If in ACCESS: treated as an abort, go to RECOVER.
  - If in RECOVER: force IDLE.
- Without the macro: no counter; timeout is tied to 0.

Test Plan:
- Reset: hold nRST=0 three cycles with req_ren=2'b11 → out_ren=0, req_busy=2'b11, grant_valid=0.
- Single read: req_ren[0]=1, addr 0x100, out_busy=0 in the first ACCESS cycle → out_ren=1, out_addr=0x100 in cycle N+1; req_busy[0]=0 with req_rdata[0]=out_rdata in the same cycle.
- Contention: both requesters continuously active, slave busy 2 cycles per access → grants alternate 1,0,1,0. The first grant goes to index 1, and no requester waits more than one transaction.
- Abort: abort_bus=1 mid-ACCESS with out_busy=1 → out_ren drops in the same cycle, state RECOVER, req_busy[g] stays 1; after out_busy falls → IDLE, then grant is re-arbitrated.
- Withdrawal: granted req_ren drops while out_busy=1 → RECOVER, no completion reported; the next request is served normally.
- Watchdog (ARB_WATCHDOG_EN, TIMEOUT_CYCLES=8): out_busy stuck at 1 → timeout pulses at the 8th busy cycle → RECOVER, then forced IDLE on the next timeout; without the macro, timeout stays 0 and the arbiter stays in ACCESS.
